// File: rtl/dither_scan_scheduler.sv
// Raster-order job scheduler for the Floyd-Steinberg error-diffusion datapath.
// Issues one handshaked job per pixel with neighbour addresses and a boundary mask.
module dither_scan_scheduler #(
    parameter int IMAGEX           = 64,
    parameter int IMAGEY           = 64,
    parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
    parameter int IMAGEXlog2       = $clog2(IMAGEX),
    parameter int IMAGEYlog2       = $clog2(IMAGEY),
    parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic                        job_valid,
    input  logic                        job_ready,
    input  logic                        job_done,
    output logic [IMAGEXlog2-1:0]       job_x,
    output logic [IMAGEYlog2-1:0]       job_y,
    output logic [IMAGE_ADDR_WIDTH-1:0] job_addr,
    output logic [3:0]                  nbr_mask,
    output logic [IMAGE_ADDR_WIDTH-1:0] nbr_addr_r,
    output logic [IMAGE_ADDR_WIDTH-1:0] nbr_addr_bl,
    output logic [IMAGE_ADDR_WIDTH-1:0] nbr_addr_b,
    output logic [IMAGE_ADDR_WIDTH-1:0] nbr_addr_br
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [IMAGEXlog2-1:0]       X_LAST    = IMAGEXlog2'(IMAGEX - 1);
    localparam logic [IMAGEYlog2-1:0]       Y_LAST    = IMAGEYlog2'(IMAGEY - 1);
    localparam logic [IMAGE_ADDR_WIDTH-1:0] ADDR_LAST = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);
    localparam logic [IMAGE_ADDR_WIDTH-1:0] OFS_R     = IMAGE_ADDR_WIDTH'(1);
    localparam logic [IMAGE_ADDR_WIDTH-1:0] OFS_BL    = IMAGE_ADDR_WIDTH'(IMAGEX - 1);
    localparam logic [IMAGE_ADDR_WIDTH-1:0] OFS_B     = IMAGE_ADDR_WIDTH'(IMAGEX);
    localparam logic [IMAGE_ADDR_WIDTH-1:0] OFS_BR    = IMAGE_ADDR_WIDTH'(IMAGEX + 1);

    state_t state;

    logic [IMAGEXlog2-1:0]       nxt_x;
    logic [IMAGEYlog2-1:0]       nxt_y;
    logic [IMAGE_ADDR_WIDTH-1:0] nxt_addr;
    logic                        nxt_right;
    logic                        nxt_below;
    logic [3:0]                  nxt_mask;
    logic [IMAGE_ADDR_WIDTH-1:0] nxt_r;
    logic [IMAGE_ADDR_WIDTH-1:0] nxt_bl;
    logic [IMAGE_ADDR_WIDTH-1:0] nxt_b;
    logic [IMAGE_ADDR_WIDTH-1:0] nxt_br;

    // Fields of the job to load next: pixel 0 from IDLE, otherwise the raster successor.
    always_comb begin
        nxt_x    = '0;
        nxt_y    = '0;
        nxt_addr = '0;
        if (state != IDLE) begin
            nxt_addr = job_addr + OFS_R;
            if (job_x == X_LAST) begin
                nxt_x = '0;
                nxt_y = job_y + IMAGEYlog2'(1);
            end else begin
                nxt_x = job_x + IMAGEXlog2'(1);
                nxt_y = job_y;
            end
        end
        nxt_right = (nxt_x != X_LAST);
        nxt_below = (nxt_y != Y_LAST);
        nxt_mask  = {nxt_below & nxt_right, nxt_below, nxt_below & (nxt_x != '0), nxt_right};
        nxt_r     = nxt_mask[0] ? nxt_addr + OFS_R  : '0;
        nxt_bl    = nxt_mask[1] ? nxt_addr + OFS_BL : '0;
        nxt_b     = nxt_mask[2] ? nxt_addr + OFS_B  : '0;
        nxt_br    = nxt_mask[3] ? nxt_addr + OFS_BR : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            job_valid   <= 1'b0;
            job_x       <= '0;
            job_y       <= '0;
            job_addr    <= '0;
            nbr_mask    <= '0;
            nbr_addr_r  <= '0;
            nbr_addr_bl <= '0;
            nbr_addr_b  <= '0;
            nbr_addr_br <= '0;
        end else if (abort) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            job_valid   <= 1'b0;
            job_x       <= '0;
            job_y       <= '0;
            job_addr    <= '0;
            nbr_mask    <= '0;
            nbr_addr_r  <= '0;
            nbr_addr_bl <= '0;
            nbr_addr_b  <= '0;
            nbr_addr_br <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= ISSUE;
                        busy        <= 1'b1;
                        job_valid   <= 1'b1;
                        job_x       <= nxt_x;
                        job_y       <= nxt_y;
                        job_addr    <= nxt_addr;
                        nbr_mask    <= nxt_mask;
                        nbr_addr_r  <= nxt_r;
                        nbr_addr_bl <= nxt_bl;
                        nbr_addr_b  <= nxt_b;
                        nbr_addr_br <= nxt_br;
                    end
                end
                ISSUE: begin
                    if (job_ready) begin
                        state     <= WAIT;
                        job_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (job_done) begin
                        if (job_addr == ADDR_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= ISSUE;
                            job_valid   <= 1'b1;
                            job_x       <= nxt_x;
                            job_y       <= nxt_y;
                            job_addr    <= nxt_addr;
                            nbr_mask    <= nxt_mask;
                            nbr_addr_r  <= nxt_r;
                            nbr_addr_bl <= nxt_bl;
                            nbr_addr_b  <= nxt_b;
                            nbr_addr_br <= nxt_br;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    job_x       <= '0;
                    job_y       <= '0;
                    job_addr    <= '0;
                    nbr_mask    <= '0;
                    nbr_addr_r  <= '0;
                    nbr_addr_bl <= '0;
                    nbr_addr_b  <= '0;
                    nbr_addr_br <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dither_scan_scheduler.sv
// Self-checking bench for dither_scan_scheduler on a 4x4 image, using a raster-walk
// reference model and randomized handshake timing.
module tb_dither_scan_scheduler;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int SIZE = W * H;
    localparam int XW   = $clog2(W);
    localparam int YW   = $clog2(H);
    localparam int AW   = $clog2(SIZE);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          job_valid;
    logic          job_ready;
    logic          job_done;
    logic [XW-1:0] job_x;
    logic [YW-1:0] job_y;
    logic [AW-1:0] job_addr;
    logic [3:0]    nbr_mask;
    logic [AW-1:0] nbr_addr_r;
    logic [AW-1:0] nbr_addr_bl;
    logic [AW-1:0] nbr_addr_b;
    logic [AW-1:0] nbr_addr_br;

    int n_checks = 0;
    int n_errors = 0;

    dither_scan_scheduler #(
        .IMAGEX(W),
        .IMAGEY(H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_done    (job_done),
        .job_x       (job_x),
        .job_y       (job_y),
        .job_addr    (job_addr),
        .nbr_mask    (nbr_mask),
        .nbr_addr_r  (nbr_addr_r),
        .nbr_addr_bl (nbr_addr_bl),
        .nbr_addr_b  (nbr_addr_b),
        .nbr_addr_br (nbr_addr_br)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: fields of pixel p derived directly from its position in the image.
    task automatic check_job(input int p);
        int x, y;
        bit r, b, bl, br;
        x  = p % W;
        y  = p / W;
        r  = (x < W - 1);
        b  = (y < H - 1);
        bl = b && (x > 0);
        br = b && r;
        check("job_x",       int'(job_x),       x);
        check("job_y",       int'(job_y),       y);
        check("job_addr",    int'(job_addr),    p);
        check("nbr_mask",    int'(nbr_mask),    (int'(br) << 3) | (int'(b) << 2) | (int'(bl) << 1) | int'(r));
        check("nbr_addr_r",  int'(nbr_addr_r),  r  ? p + 1     : 0);
        check("nbr_addr_bl", int'(nbr_addr_bl), bl ? p + W - 1 : 0);
        check("nbr_addr_b",  int'(nbr_addr_b),  b  ? p + W     : 0);
        check("nbr_addr_br", int'(nbr_addr_br), br ? p + W + 1 : 0);
    endtask

    task automatic check_zero_outputs();
        check("rst_busy",        int'(busy),        0);
        check("rst_done",        int'(done),        0);
        check("rst_job_valid",   int'(job_valid),   0);
        check("rst_job_x",       int'(job_x),       0);
        check("rst_job_y",       int'(job_y),       0);
        check("rst_job_addr",    int'(job_addr),    0);
        check("rst_nbr_mask",    int'(nbr_mask),    0);
        check("rst_nbr_addr_r",  int'(nbr_addr_r),  0);
        check("rst_nbr_addr_bl", int'(nbr_addr_bl), 0);
        check("rst_nbr_addr_b",  int'(nbr_addr_b),  0);
        check("rst_nbr_addr_br", int'(nbr_addr_br), 0);
    endtask

    // One full pass; rnd randomizes ready/done latency and sprinkles ignored inputs.
    task automatic run_pass(input bit rnd, input int abort_idx, input int bp_idx);
        int idx, cyc, lat, hold;
        bit in_wait, fin;
        idx = 0; cyc = 0; lat = 0; hold = 0; in_wait = 0; fin = 0;
        check("idle_busy", int'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!fin) begin
            if (cyc > 4000) begin
                check("timeout", 0, 1);
                fin = 1;
            end else if (idx == SIZE) begin
                check("done_pulse", int'(done),      1);
                check("done_busy",  int'(busy),      1);
                check("done_valid", int'(job_valid), 0);
                if (!rnd && bp_idx < 0)
                    check("start_to_done", cyc, 2 * SIZE + 1);
                start = 1'b0; job_done = 1'b0; job_ready = 1'b0;
                tick();
                check("done_width", int'(done), 0);
                check("busy_after", int'(busy), 0);
                fin = 1;
            end else begin
                check("busy",      int'(busy),      1);
                check("no_done",   int'(done),      0);
                check("job_valid", int'(job_valid), int'(!in_wait));
                check_job(idx);
                start = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
                if (!in_wait) begin
                    job_done = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
                    if (rnd) job_ready = ($urandom_range(0, 2) != 0);
                    else if (idx == bp_idx && hold < 5) begin
                        job_ready = 1'b0;
                        hold++;
                    end else job_ready = 1'b1;
                    tick();
                    cyc++;
                    if (job_ready) begin
                        in_wait = 1;
                        lat = rnd ? int'($urandom_range(0, 3)) : 0;
                    end
                end else if (idx == abort_idx) begin
                    abort = 1'b1; job_done = 1'b1; start = 1'b1;
                    tick();
                    abort = 1'b0; job_done = 1'b0; start = 1'b0;
                    check("abort_busy",  int'(busy),      0);
                    check("abort_valid", int'(job_valid), 0);
                    check("abort_done",  int'(done),      0);
                    tick();
                    check("abort_idle",    int'(busy), 0);
                    check("abort_no_done", int'(done), 0);
                    fin = 1;
                end else begin
                    job_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    job_done  = (lat == 0);
                    tick();
                    cyc++;
                    if (lat == 0) begin
                        idx++;
                        in_wait = 0;
                    end else lat--;
                end
            end
        end
        job_ready = 1'b0; job_done = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; job_ready = 1'b0; job_done = 1'b0;
        tick();
        tick();
        check_zero_outputs();
        rst_n = 1'b1;
        tick();
        check("idle_after_rst", int'(busy), 0);

        run_pass(1'b0, -1, -1);
        run_pass(1'b0, -1, 6);
        run_pass(1'b0, 9, -1);
        run_pass(1'b0, -1, -1);
        for (int i = 0; i < 4; i++) run_pass(1'b1, -1, -1);

        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy",  int'(busy),      0);
        check("abort_start_valid", int'(job_valid), 0);
        tick();
        check("abort_start_stay", int'(busy), 0);

        // Asynchronous reset landing between clock edges in the middle of a pass.
        start = 1'b1;
        tick();
        start = 1'b0; job_ready = 1'b1; job_done = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("pre_rst_busy", int'(busy), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs();
        job_ready = 1'b0; job_done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_idle",  int'(busy),      0);
            check("post_rst_valid", int'(job_valid), 0);
        end

        run_pass(1'b1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dither_scan_scheduler.md
# dither_scan_scheduler

Sequences the Floyd-Steinberg error-diffusion datapath across the image in raster order. The scheduler issues one job per pixel, holding the current pixel's coordinates and linear address, the addresses of its four error-diffusion neighbours and a validity mask for image boundaries. It waits for the datapath to finish each job before advancing. It sits between the top-level control (start/abort) and the quantize/diffuse datapath, and replaces free-running pixel counting with a handshaked, boundary-aware walk.

## Interface
- IMAGEX, 64, image width in pixels (>= 2)
- IMAGEY, 64, image height in pixels (>= 2)
- IMAGE_SIZE, IMAGEX*IMAGEY, total pixels
- IMAGEXlog2 / IMAGEYlog2, $clog2(IMAGEX) / $clog2(IMAGEY), coordinate widths
- IMAGE_ADDR_WIDTH, $clog2(IMAGE_SIZE), linear address width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a full-image pass; sampled only in IDLE
- abort  in  1  terminate pass; priority over every other input
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last pixel's job completes
- job_valid  out  1  job fields valid; held until accepted
- job_ready  in  1  datapath accepts job when job_valid & job_ready
- job_done  in  1  datapath finished the accepted job
- job_x  out  IMAGEXlog2  current column
- job_y  out  IMAGEYlog2  current row
- job_addr  out  IMAGE_ADDR_WIDTH  y*IMAGEX + x
- nbr_mask  out  4  [0]=right, [1]=below-left, [2]=below, [3]=below-right valid
- nbr_addr_r / nbr_addr_bl / nbr_addr_b / nbr_addr_br  out  IMAGE_ADDR_WIDTH each  neighbour addresses; 0 when the mask bit is 0

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: outputs idle; start=1 -> ISSUE with x=y=addr=0.
- ISSUE: job_valid=1; on job_valid & job_ready -> WAIT.
- WAIT: job_valid=0. On job_done: if addr==IMAGE_SIZE-1 -> DONE; otherwise advance and return to ISSUE.
- Advance: x+1. When x==IMAGEX-1: x wraps to 0 and y increments. addr always increments by 1 and is maintained incrementally (no multiplier).
- DONE: done=1 for exactly one cycle -> IDLE.
- Mask:
  - right = x<IMAGEX-1
  - below = y<IMAGEY-1
  - below-left = below & x>0
  - below-right = below & right
- Neighbour addresses:
  - right: addr+1
  - below-left: addr+IMAGEX-1
  - below: addr+IMAGEX
  - below-right: addr+IMAGEX+1
  - All computed at IMAGE_ADDR_WIDTH and forced to 0 when masked. Valid neighbours never exceed IMAGE_SIZE-1, so no overflow handling is needed.
- Job fields (x, y, addr, mask, nbr_*) are registered and stable from ISSUE entry through the end of WAIT.
- abort=1 in any state -> IDLE next cycle. Counters are cleared and no done pulse is issued. If abort and start are both high in IDLE, abort wins and the block stays IDLE.
- Ignored inputs:
  - start outside IDLE
  - job_done outside WAIT
  - job_ready outside ISSUE
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, job_valid, job_x, job_y, job_addr, nbr_mask and all nbr_addr outputs = 0. Reset mid-pass discards the pass.

## Timing
- start sampled at edge N -> job_valid=1 and busy=1 from N+1.
- Handshake at edge M -> job_valid=0 from M+1.
- job_done at edge K (in WAIT) -> next job_valid=1 from K+1, or done=1 at K+1 for the last pixel.
- busy drops the cycle after the done pulse.
- Minimum per-pixel period is 2 cycles (ready already high, job_done in the first WAIT cycle).
- Full pass with zero datapath latency takes 2*IMAGE_SIZE+1 cycles from start to done.
- job_ready may be held high continuously. job_valid never drops before acceptance.

## Test plan
- Bench parameters: IMAGEX=IMAGEY=4, job_ready=1, job_done asserted 1 cycle after each handshake, one start pulse. Required response: 16 jobs with addr 0..15 in order; done pulses once, 33 cycles after start; busy low afterwards.
- Boundaries, same run:
  - Pixel (0,0): mask=4'b1101, nbr_addr_r=1, nbr_addr_bl=0, nbr_addr_b=4, nbr_addr_br=5.
  - Pixel (3,0): mask=4'b0110, nbr_addr_bl=6, nbr_addr_b=7.
  - Pixel (3,3): mask=0, all nbr_addr=0.
- Backpressure: job_ready low for 5 cycles on pixel 6 -> job_valid and all job fields held (x=2, y=1, addr=6); accepted on the first cycle ready rises.
- Abort during WAIT at pixel 9 -> IDLE next cycle, busy=0, no done pulse. A new start restarts at addr 0.
- Illegal inputs:
  - start while busy -> ignored, traversal unaffected.
  - job_done during ISSUE -> ignored, no advance.
  - abort+start together in IDLE -> stays IDLE.
- Assert rst_n low asynchronously mid-pass (between clock edges) -> all outputs 0 immediately. After release, block idles until start.
